// File: rtl/ascon_pkg.sv
// Shared types and helpers for the Ascon permutation core and its round datapath.
package ascon_pkg;

  localparam int ASCON_MAX_ROUNDS = 12;

  // x0 is word [0], x4 is word [4]
  typedef logic [4:0][63:0] ascon_state_t;
  typedef logic [3:0]       rnd_t;
  typedef logic [3:0]       rounds_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} perm_fsm_t;

  // Round constant derived arithmetically from the round index: {~i, i}
  function automatic logic [7:0] ascon_rc(input rnd_t i);
    return {~i, i};
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, 5-bit S-box layer, linear diffusion.
module ascon_round
  import ascon_pkg::*;
(
  input  logic         en_i,
  input  rnd_t         rnd_i,
  input  ascon_state_t state_i,
  output ascon_state_t state_o
);

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
  logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;

  always_comb begin
    w_x0 = state_i[0];
    w_x1 = state_i[1];
    w_x2 = state_i[2] ^ {56'd0, ascon_rc(rnd_i)};
    w_x3 = state_i[3];
    w_x4 = state_i[4];
    // bitsliced S-box
    w_x0 = w_x0 ^ w_x4;
    w_x4 = w_x4 ^ w_x3;
    w_x2 = w_x2 ^ w_x1;
    w_t0 = ~w_x0 & w_x1;
    w_t1 = ~w_x1 & w_x2;
    w_t2 = ~w_x2 & w_x3;
    w_t3 = ~w_x3 & w_x4;
    w_t4 = ~w_x4 & w_x0;
    w_x0 = w_x0 ^ w_t1;
    w_x1 = w_x1 ^ w_t2;
    w_x2 = w_x2 ^ w_t3;
    w_x3 = w_x3 ^ w_t4;
    w_x4 = w_x4 ^ w_t0;
    w_x1 = w_x1 ^ w_x0;
    w_x0 = w_x0 ^ w_x4;
    w_x3 = w_x3 ^ w_x2;
    w_x2 = ~w_x2;

    state_o[0] = w_x0 ^ rotr(w_x0, 19) ^ rotr(w_x0, 28);
    state_o[1] = w_x1 ^ rotr(w_x1, 61) ^ rotr(w_x1, 39);
    state_o[2] = w_x2 ^ rotr(w_x2, 1)  ^ rotr(w_x2, 6);
    state_o[3] = w_x3 ^ rotr(w_x3, 10) ^ rotr(w_x3, 17);
    state_o[4] = w_x4 ^ rotr(w_x4, 7)  ^ rotr(w_x4, 41);
    if (!en_i) state_o = state_i;
  end

endmodule

// File: rtl/ascon_permutation_core.sv
// Iterative Ascon p^nr engine, UNROLL rounds per clock, valid/ready on both sides.
// Define ASCON_PERM_ZEROIZE_EN to clear the state register when a result is consumed.
module ascon_permutation_core
  import ascon_pkg::*;
#(
  parameter int UNROLL     = 1,
  parameter int MAX_ROUNDS = ASCON_MAX_ROUNDS
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  rounds_t      rounds_i,
  input  ascon_state_t state_i,
  output logic         valid_o,
  input  logic         ready_i,
  output ascon_state_t state_o,
  output logic         busy_o
);

  perm_fsm_t    r_fsm;
  ascon_state_t r_state;
  rnd_t         r_rnd;
  rounds_t      r_rem;
  logic         r_ready;
  logic         r_valid;
  logic         r_busy;

  ascon_state_t w_chain [UNROLL+1];
  rounds_t      w_nr_eff;
  rounds_t      w_k;
  logic         w_last;

  assign w_chain[0] = r_state;

  // Stages at or beyond the remaining count pass the state through untouched
  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    logic w_en;
    rnd_t w_rnd;
    assign w_en  = (r_fsm == RUN) && (rounds_t'(g) < r_rem);
    assign w_rnd = r_rnd + rnd_t'(g);
    ascon_round u_round (
      .en_i    (w_en),
      .rnd_i   (w_rnd),
      .state_i (w_chain[g]),
      .state_o (w_chain[g+1])
    );
  end

  assign w_nr_eff = (rounds_i > rounds_t'(MAX_ROUNDS)) ? rounds_t'(MAX_ROUNDS) : rounds_i;
  assign w_last   = (r_rem <= rounds_t'(UNROLL));
  assign w_k      = w_last ? r_rem : rounds_t'(UNROLL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_rnd   <= '0;
      r_rem   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (valid_i && r_ready) begin
            r_state <= state_i;
            r_rnd   <= rnd_t'(MAX_ROUNDS) - w_nr_eff;
            r_rem   <= w_nr_eff;
            r_ready <= 1'b0;
            if (w_nr_eff == '0) begin
              r_fsm   <= DONE;
              r_valid <= 1'b1;
            end else begin
              r_fsm  <= RUN;
              r_busy <= 1'b1;
            end
          end
        end
        RUN: begin
          r_state <= w_chain[UNROLL];
          r_rem   <= r_rem - w_k;
          r_rnd   <= r_rnd + w_k;
          if (w_last) begin
            r_fsm   <= DONE;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          // ready_o only returns after this edge, so no same-cycle re-accept
          if (ready_i) begin
            r_fsm   <= IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
`ifdef ASCON_PERM_ZEROIZE_EN
            r_state <= '0;
`endif
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign busy_o  = r_busy;
  assign state_o = r_state;

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      a_rnd_range: assert (r_rnd <= rnd_t'(MAX_ROUNDS));
      if (valid_i && r_ready) begin
        a_rounds_known: assert (!$isunknown(rounds_i));
      end
    end
  end

endmodule

// File: tb/tb_ascon_permutation_core.sv
// Directed bench for ascon_permutation_core at UNROLL=1 and UNROLL=4 against a table-driven Ascon model.
module tb_ascon_permutation_core;
  import ascon_pkg::*;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [7:0] RC_TAB [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  logic         clk;
  logic         rst_n;
  logic         valid_i;
  logic         ready_i;
  rounds_t      rounds_i;
  ascon_state_t st_in;
  logic         rdy1, vld1, busy1;
  logic         rdy4, vld4, busy4;
  ascon_state_t so1, so4;

  int n_checks;
  int n_fail;

  ascon_state_t sA, sB, sC;

  ascon_permutation_core #(.UNROLL(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(rdy1),
    .rounds_i(rounds_i), .state_i(st_in), .valid_o(vld1), .ready_i(ready_i),
    .state_o(so1), .busy_o(busy1));

  ascon_permutation_core #(.UNROLL(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(rdy4),
    .rounds_i(rounds_i), .state_i(st_in), .valid_o(vld4), .ready_i(ready_i),
    .state_o(so4), .busy_o(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x};
    return d[n +: 64];
  endfunction

  function automatic ascon_state_t ref_perm(input ascon_state_t s, input int nr);
    logic [63:0] x [5];
    logic [4:0]  v;
    ascon_state_t r;
    for (int i = 0; i < 5; i++) x[i] = s[i];
    for (int rd = 12 - nr; rd < 12; rd++) begin
      x[2][7:0] = x[2][7:0] ^ RC_TAB[rd];
      for (int j = 0; j < 64; j++) begin
        v = SBOX[{x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]}];
        x[0][j] = v[4];
        x[1][j] = v[3];
        x[2][j] = v[2];
        x[3][j] = v[1];
        x[4][j] = v[0];
      end
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    end
    for (int i = 0; i < 5; i++) r[i] = x[i];
    return r;
  endfunction

  task automatic run_req(input rounds_t nr, input ascon_state_t st, input bit hold, input string name);
    int cyc, lat1, lat4, busy_cnt, nre, w;
    ascon_state_t s1, s4, exp_s;
    nre   = (nr > 4'd12) ? 12 : int'(nr);
    exp_s = ref_perm(st, nre);
    s1 = '0;
    s4 = '0;
    @(negedge clk);
    w = 0;
    while (!(rdy1 && rdy4) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({name, "_idle"}, rdy1 && rdy4, 1'b1);
    ready_i  = !hold;
    valid_i  = 1'b1;
    rounds_i = nr;
    st_in    = st;
    @(posedge clk);
    #1;
    valid_i  = 1'b0;
    rounds_i = 4'd5;
    st_in    = '1;
    cyc = 0; lat1 = -1; lat4 = -1; busy_cnt = 0;
    @(negedge clk);
    check({name, "_rdy_low"}, rdy1 | rdy4, 1'b0);
    while (cyc < 40) begin
      if (busy1) busy_cnt++;
      if (lat1 < 0 && vld1) begin lat1 = cyc; s1 = so1; end
      if (lat4 < 0 && vld4) begin lat4 = cyc; s4 = so4; end
      if (lat1 >= 0 && lat4 >= 0) break;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check({name, "_lat_u1"},   lat1, nre);
    check({name, "_lat_u4"},   lat4, (nre + 3) / 4);
    check({name, "_state_u1"}, s1, exp_s);
    check({name, "_state_u4"}, s4, exp_s);
    check({name, "_busy_u1"},  busy_cnt, nre);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        valid_i  = 1'b1;
        rounds_i = 4'd1;
        st_in    = sC;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        check({name, "_hold_vld"}, {vld1, vld4, rdy1, rdy4}, 4'b1100);
        check({name, "_hold_s1"},  so1, exp_s);
        check({name, "_hold_s4"},  so4, exp_s);
      end
      ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({name, "_rel_ctrl"}, {vld1, vld4, rdy1, rdy4}, 4'b0011);
`ifdef ASCON_PERM_ZEROIZE_EN
      check({name, "_zeroize"}, so1, '0);
`else
      check({name, "_retain"}, so1, exp_s);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sA = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
          64'h8000000000000001, 64'hdeadbeefcafef00d};
    sB = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
          64'h4444444444444444, 64'h5555555555555555};
    sC = {64'ha5a5a5a5a5a5a5a5, 64'h5a5a5a5a5a5a5a5a, 64'h0000000000000080,
          64'hffffffffffffffff, 64'h00000000deadbeef};
    rst_n    = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    rounds_i = '0;
    st_in    = sA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl_u1", {rdy1, vld1, busy1}, 3'b100);
    check("reset_ctrl_u4", {rdy4, vld4, busy4}, 3'b100);
    check("reset_state",   so1 | so4, '0);
    rst_n = 1'b1;

    run_req(4'd12, '0, 1'b0, "p12_zero");
    run_req(4'd8,  sA, 1'b0, "p8");
    run_req(4'd6,  sB, 1'b0, "p6");
    run_req(4'd0,  sC, 1'b0, "p0");
    run_req(4'd15, sA, 1'b0, "nr15");
    run_req(4'd1,  sB, 1'b0, "p1");
    run_req(4'd3,  sB, 1'b1, "hold");

    // reset in the middle of a 12-round run
    @(negedge clk);
    valid_i  = 1'b1;
    rounds_i = 4'd12;
    st_in    = sC;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrun_busy", busy1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_rst_ctrl", {rdy1, vld1, busy1, rdy4, vld4, busy4}, 6'b100100);
    check("midrun_rst_state", so1 | so4, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(4'd12, sC, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
